wb_decoder: RTL

Single-master Wishbone pipelined-mode interconnect between the CPU core and the SoC slaves (bootrom, internal RAM, IO). It decodes the CPU address and routes the strobe to one slave. It steers that slave's data, ack and stall back to the CPU. It allows only one outstanding transaction and raises a bus error on unmapped addresses or, optionally, on a slave that never acks.

---
 rtl/wb_decoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_decoder.sv
// Single-master Wishbone pipelined-mode decoder: routes one outstanding request to ROM/RAM/IO.
// Optional ack timeout is built only when WB_TIMEOUT_EN is defined.
module wb_decoder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_wb_err,
  output logic [13:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic        o_s_we,
  output logic        o_rom_stb,
  output logic        o_ram_stb,
  output logic        o_io_stb,
  input  logic [31:0] i_rom_data,
  input  logic [31:0] i_ram_data,
  input  logic [31:0] i_io_data,
  input  logic        i_rom_ack,
  input  logic        i_ram_ack,
  input  logic        i_io_ack,
  input  logic        i_rom_stall,
  input  logic        i_ram_stall,
  input  logic        i_io_stall
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_ROM  = 2'd1;
  localparam logic [1:0] SEL_RAM  = 2'd2;
  localparam logic [1:0] SEL_IO   = 2'd3;

  localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

  logic [1:0]  state, state_d;
  logic [1:0]  sel, sel_d;
  logic [1:0]  csel;
  logic        request;
  logic        csel_stall;
  logic        sel_ack;
  logic [31:0] sel_data;
  logic        rom_stb_c, ram_stb_c, io_stb_c;
  logic        ack_c, stall_c, err_c;
  logic [31:0] data_c;
  logic        timeout_hit;

  assign o_s_addr = i_addr[15:2];
  assign o_s_data = i_data;
  assign o_s_we   = i_we;
  assign request  = i_wb_cyc & i_wb_stb;

  always_comb begin
    csel = SEL_NONE;
    if (i_addr[31:16] == 16'hb000) csel = i_addr[15] ? SEL_RAM : SEL_ROM;
    else if (i_addr[31:16] == 16'hc000) csel = SEL_IO;
  end

  always_comb begin
    case (csel)
      SEL_ROM: csel_stall = i_rom_stall;
      SEL_RAM: csel_stall = i_ram_stall;
      SEL_IO:  csel_stall = i_io_stall;
      default: csel_stall = 1'b0;
    endcase
  end

  // Only the latched slave is listened to, so stray or late acks never leak through.
  always_comb begin
    case (sel)
      SEL_ROM: begin sel_ack = i_rom_ack; sel_data = i_rom_data; end
      SEL_RAM: begin sel_ack = i_ram_ack; sel_data = i_ram_data; end
      SEL_IO:  begin sel_ack = i_io_ack;  sel_data = i_io_data;  end
      default: begin sel_ack = 1'b0;      sel_data = 32'd0;      end
    endcase
  end

`ifdef WB_TIMEOUT_EN
  logic [9:0] cnt, cnt_inc;

  assign cnt_inc     = cnt + 10'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 10'd0;
    end else if (state != WAIT_ACK) begin
      cnt <= 10'd0;
    end else if (!sel_ack) begin
      cnt <= cnt_inc;
    end
  end

  logic unused_bits;
  assign unused_bits = ^i_addr[1:0];
`else
  assign timeout_hit = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{i_addr[1:0], TIMEOUT_W};
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state;
    sel_d     = sel;
    rom_stb_c = 1'b0;
    ram_stb_c = 1'b0;
    io_stb_c  = 1'b0;
    ack_c     = 1'b0;
    stall_c   = 1'b0;
    err_c     = 1'b0;
    data_c    = 32'd0;
    case (state)
      IDLE: begin
        rom_stb_c = request && (csel == SEL_ROM);
        ram_stb_c = request && (csel == SEL_RAM);
        io_stb_c  = request && (csel == SEL_IO);
        stall_c   = csel_stall;
        if (request) begin
          if (csel == SEL_NONE) begin
            state_d = ERR;
          end else if (!csel_stall) begin
            state_d = WAIT_ACK;
            sel_d   = csel;
          end
        end
      end
      WAIT_ACK: begin
        stall_c = 1'b1;
        ack_c   = sel_ack & i_wb_cyc;
        data_c  = ack_c ? sel_data : 32'd0;
        // Ack and abort take priority over timeout expiry.
        if (!i_wb_cyc || sel_ack) begin
          state_d = IDLE;
          sel_d   = SEL_NONE;
        end else if (timeout_hit) begin
          state_d = ERR;
          sel_d   = SEL_NONE;
        end
      end
      ERR: begin
        err_c   = 1'b1;
        stall_c = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= SEL_NONE;
    end else begin
      state <= state_d;
      sel   <= sel_d;
    end
  end

  // Outputs are forced low while reset is held, even if the master drives a request.
  assign o_rom_stb  = rom_stb_c & reset;
  assign o_ram_stb  = ram_stb_c & reset;
  assign o_io_stb   = io_stb_c  & reset;
  assign o_wb_ack   = ack_c     & reset;
  assign o_wb_stall = stall_c   & reset;
  assign o_wb_err   = err_c     & reset;
  assign o_data     = data_c & {32{reset}};

endmodule
